// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment loopback decoder: active-low glyph
// codes, slot count, decode result type and the slot-targeting helper.
package seg_pkg;

  localparam int DIGITS = 6;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Idle bus as seen on the wire: nothing selected, all segments dark.
  localparam logic [13:0] SAMPLE_IDLE = {6'h3F, 8'hFF};

  typedef enum logic [1:0] {
    GLYPH_HEX,
    GLYPH_BLANK,
    GLYPH_INVALID
  } glyph_kind_e;

  typedef struct packed {
    glyph_kind_e kind;
    logic [3:0]  nibble;
  } glyph_t;

  // All-low select is static mode; a single low bit picks one slot; anything
  // else is the blanking interval between scan steps.
  function automatic logic [DIGITS-1:0] target_mask(input logic [DIGITS-1:0] sel);
    logic [DIGITS-1:0] lo;
    lo = ~sel;
    if (sel == '0)
      return '1;
    if ((lo != '0) && ((lo & (lo - 1'b1)) == '0))
      return lo;
    return '0;
  endfunction

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational active-low segment code to {kind, nibble}; blank and invalid
// codes report nibble 0.
module seg_glyph_decode
  import seg_pkg::*;
(
  input  logic [6:0] code,
  output glyph_t     glyph
);

  always_comb begin
    glyph.kind   = GLYPH_HEX;
    glyph.nibble = 4'h0;
    case (code)
      SEG_0:     glyph.nibble = 4'h0;
      SEG_1:     glyph.nibble = 4'h1;
      SEG_2:     glyph.nibble = 4'h2;
      SEG_3:     glyph.nibble = 4'h3;
      SEG_4:     glyph.nibble = 4'h4;
      SEG_5:     glyph.nibble = 4'h5;
      SEG_6:     glyph.nibble = 4'h6;
      SEG_7:     glyph.nibble = 4'h7;
      SEG_8:     glyph.nibble = 4'h8;
      SEG_9:     glyph.nibble = 4'h9;
      SEG_A:     glyph.nibble = 4'hA;
      SEG_B:     glyph.nibble = 4'hB;
      SEG_C:     glyph.nibble = 4'hC;
      SEG_D:     glyph.nibble = 4'hD;
      SEG_E:     glyph.nibble = 4'hE;
      SEG_F:     glyph.nibble = 4'hF;
      SEG_BLANK: glyph.kind   = GLYPH_BLANK;
      default:   glyph.kind   = GLYPH_INVALID;
    endcase
  end

endmodule

// File: rtl/seg_decoder.sv
// Seven-segment loopback decoder: debounces {seg_sel, seg_led}, decodes each
// committed glyph into per-digit slots. SEG_DEC_SYNC_EN adds a 2-flop input synchronizer.
module seg_decoder
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [5:0]  seg_sel,
  input  logic [7:0]  seg_led,
  output logic [23:0] digit_val,
  output logic [5:0]  digit_dp,
  output logic [5:0]  digit_valid,
  output logic        upd_pulse,
  output logic        err_pulse,
  output logic [7:0]  err_cnt
);

  localparam logic [7:0] COMMIT_AT = 8'(STABLE_CYCLES - 1);

  logic [13:0]       samp;
  logic [13:0]       prev;
  logic [7:0]        stab_cnt;
  logic              commit;
  logic [DIGITS-1:0] tgt;
  glyph_t            glyph;

`ifdef SEG_DEC_SYNC_EN
  logic [13:0] sync_a, sync_b;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync_a <= SAMPLE_IDLE;
      sync_b <= SAMPLE_IDLE;
    end else begin
      sync_a <= {seg_sel, seg_led};
      sync_b <= sync_a;
    end
  end

  assign samp = sync_b;
`else
  assign samp = {seg_sel, seg_led};
`endif

  // stab_cnt counts repeats after the first sample of a run, so it equals
  // STABLE_CYCLES-1 for exactly one cycle once the run is long enough.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      prev     <= SAMPLE_IDLE;
      stab_cnt <= 8'd0;
    end else begin
      prev <= samp;
      if (samp != prev)
        stab_cnt <= 8'd0;
      else if (stab_cnt != 8'hFF)
        stab_cnt <= stab_cnt + 8'd1;
    end
  end

  assign commit = (stab_cnt == COMMIT_AT);
  assign tgt    = commit ? target_mask(prev[13:8]) : '0;

  seg_glyph_decode u_glyph (
    .code  (prev[6:0]),
    .glyph (glyph)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      digit_val   <= '0;
      digit_dp    <= '0;
      digit_valid <= '0;
      upd_pulse   <= 1'b0;
      err_pulse   <= 1'b0;
      err_cnt     <= 8'd0;
    end else begin
      upd_pulse <= 1'b0;
      err_pulse <= 1'b0;
      if (tgt != '0) begin
        if (glyph.kind == GLYPH_INVALID) begin
          err_pulse <= 1'b1;
          if (err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'd1;
        end else begin
          upd_pulse <= 1'b1;
          for (int i = 0; i < DIGITS; i++) begin
            if (tgt[i]) begin
              digit_val[4*i +: 4] <= glyph.nibble;
              digit_dp[i]         <= ~prev[7];
              digit_valid[i]      <= (glyph.kind == GLYPH_HEX);
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_decoder.sv
// Bench for seg_decoder: directed vector table, hand-written corner sequences
// and random scans, all compared every cycle against a sample-history model.
module tb_seg_decoder;

  localparam int SC = 4;
`ifdef SEG_DEC_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  localparam logic [6:0] HEX_TAB [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                         7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [5:0]  seg_sel = 6'h3F;
  logic [7:0]  seg_led = 8'hFF;
  logic [23:0] digit_val;
  logic [5:0]  digit_dp, digit_valid;
  logic        upd_pulse, err_pulse;
  logic [7:0]  err_cnt;

  seg_decoder #(.STABLE_CYCLES(SC)) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .seg_sel     (seg_sel),
    .seg_led     (seg_led),
    .digit_val   (digit_val),
    .digit_dp    (digit_dp),
    .digit_valid (digit_valid),
    .upd_pulse   (upd_pulse),
    .err_pulse   (err_pulse),
    .err_cnt     (err_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  int errors = 0;
  int checks = 0;
  int n_upd, n_err;

  // Reference state: what the outputs should read after each edge.
  logic [3:0]  m_val [6];
  bit          m_dp [6];
  bit          m_valid [6];
  bit          m_upd, m_err;
  int          m_cnt;
  logic [13:0] hist [$];
  logic [13:0] pipe [$];

  function automatic int decode(input logic [6:0] c);
    for (int k = 0; k < 16; k++)
      if (HEX_TAB[k] == c) return k;
    if (c == 7'h7F) return 16;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // A glyph commits on the edge after STABLE identical samples that were
  // preceded by a different sample.
  task automatic model_edge(input logic [13:0] in_now, input bit rst);
    logic [13:0] s, last;
    logic [5:0]  sel;
    logic [7:0]  led;
    bit          run_ok;
    int          n, code, zeros;
    m_upd = 0;
    m_err = 0;
    if (rst) begin
      for (int i = 0; i < 6; i++) begin
        m_val[i] = 4'h0; m_dp[i] = 0; m_valid[i] = 0;
      end
      m_cnt = 0;
      hist.delete();
      hist.push_back(14'h3FFF);
      pipe.delete();
      pipe.push_back(14'h3FFF);
      pipe.push_back(14'h3FFF);
      return;
    end
    if (LAT == 2) begin
      s = pipe.pop_front();
      pipe.push_back(in_now);
    end else begin
      s = in_now;
    end
    n = hist.size();
    if (n >= SC + 1) begin
      last = hist[n-1];
      run_ok = (hist[n-SC-1] != last);
      for (int k = n - SC; k < n; k++)
        if (hist[k] != last) run_ok = 0;
      if (run_ok) begin
        sel = last[13:8];
        led = last[7:0];
        zeros = $countones(~sel);
        code = decode(led[6:0]);
        if (zeros == 6 || zeros == 1) begin
          if (code < 0) begin
            m_err = 1;
            if (m_cnt < 255) m_cnt++;
          end else begin
            m_upd = 1;
            for (int i = 0; i < 6; i++) begin
              if (zeros == 6 || sel[i] == 1'b0) begin
                m_val[i]   = (code < 16) ? 4'(code) : 4'h0;
                m_dp[i]    = ~led[7];
                m_valid[i] = (code < 16);
              end
            end
          end
        end
      end
    end
    hist.push_back(s);
    if (hist.size() > SC + 1) void'(hist.pop_front());
  endtask

  task automatic cyc(input logic [5:0] sel, input logic [7:0] led);
    logic [23:0] ev;
    logic [5:0]  evl, edp;
    seg_sel = sel;
    seg_led = led;
    @(posedge sys_clk);
    model_edge({sel, led}, sys_rst);
    #1;
    for (int i = 0; i < 6; i++) begin
      ev[4*i +: 4] = m_val[i];
      evl[i] = m_valid[i];
      edp[i] = m_dp[i];
    end
    chk("model", {18'h0, digit_val, digit_valid, digit_dp, upd_pulse, err_pulse, err_cnt},
        {18'h0, ev, evl, edp, m_upd, m_err, 8'(m_cnt)});
    if (upd_pulse === 1'b1) n_upd++;
    if (err_pulse === 1'b1) n_err++;
  endtask

  typedef struct {
    logic [5:0]  sel;
    logic [7:0]  led;
    int          hold;
    logic [23:0] val;
    logic [5:0]  valid;
    logic [5:0]  dp;
    logic [7:0]  ecnt;
    int          nupd;
    int          nerr;
  } vec_t;

  vec_t tab [$];

  task automatic add_vec(input logic [5:0] sel, input logic [7:0] led, input int hold,
                         input logic [23:0] val, input logic [5:0] valid, input logic [5:0] dp,
                         input logic [7:0] ecnt, input int nupd, input int nerr);
    vec_t v;
    v = '{sel, led, hold, val, valid, dp, ecnt, nupd, nerr};
    tab.push_back(v);
  endtask

  initial begin
    logic [5:0] one, rsel;
    logic [7:0] rled;
    int         k, hold;

    add_vec(6'h00, 8'hC0, 4, 24'h000000, 6'h3F, 6'h00, 8'd0, 1, 0);
    add_vec(6'h3E, 8'hF9, 8, 24'h000001, 6'h3F, 6'h00, 8'd0, 1, 0);
    add_vec(6'h3D, 8'hA4, 8, 24'h000021, 6'h3F, 6'h00, 8'd0, 1, 0);
    add_vec(6'h3B, 8'hB0, 8, 24'h000321, 6'h3F, 6'h00, 8'd0, 1, 0);
    add_vec(6'h37, 8'h99, 8, 24'h004321, 6'h3F, 6'h00, 8'd0, 1, 0);
    add_vec(6'h2F, 8'h92, 8, 24'h054321, 6'h3F, 6'h00, 8'd0, 1, 0);
    add_vec(6'h1F, 8'h82, 8, 24'h654321, 6'h3F, 6'h00, 8'd0, 1, 0);
    add_vec(6'h3E, 8'h7F, 4, 24'h654320, 6'h3E, 6'h01, 8'd0, 1, 0);
    add_vec(6'h3E, 8'hFF, 4, 24'h654320, 6'h3E, 6'h00, 8'd0, 1, 0);
    add_vec(6'h3E, 8'hFE, 4, 24'h654320, 6'h3E, 6'h00, 8'd1, 0, 1);
    add_vec(6'h3E, 8'hFE, 3, 24'h654320, 6'h3E, 6'h00, 8'd1, 0, 0);
    add_vec(6'h33, 8'hC0, 5, 24'h654320, 6'h3E, 6'h00, 8'd1, 0, 0);
    add_vec(6'h00, 8'h00, 4, 24'h888888, 6'h3F, 6'h3F, 8'd1, 1, 0);
    add_vec(6'h3F, 8'hC0, 6, 24'h888888, 6'h3F, 6'h3F, 8'd1, 0, 0);
    add_vec(6'h1F, 8'h86, 5, 24'hE88888, 6'h3F, 6'h1F, 8'd1, 1, 0);

    sys_rst = 1'b1;
    repeat (2) cyc(6'h3F, 8'hFF);
    chk("reset_val", 64'(digit_val), 64'h0);
    chk("reset_flags", {56'h0, digit_valid, digit_dp, upd_pulse, err_pulse, err_cnt}, 64'h0);
    sys_rst = 1'b0;

    foreach (tab[i]) begin
      n_upd = 0;
      n_err = 0;
      repeat (tab[i].hold) cyc(tab[i].sel, tab[i].led);
      repeat (3) cyc(6'h3F, 8'hFF);
      chk($sformatf("vec%0d_val", i), 64'(digit_val), 64'(tab[i].val));
      chk($sformatf("vec%0d_valid_dp", i), 64'({digit_valid, digit_dp}), 64'({tab[i].valid, tab[i].dp}));
      chk($sformatf("vec%0d_err_cnt", i), 64'(err_cnt), 64'(tab[i].ecnt));
      chk($sformatf("vec%0d_pulses", i), 64'({n_upd[15:0], n_err[15:0]}),
          64'({tab[i].nupd[15:0], tab[i].nerr[15:0]}));
    end

    // 300 back-to-back invalid runs on alternating slots drive err_cnt into saturation.
    n_err = 0;
    for (int r = 0; r < 300; r++)
      repeat (SC) cyc((r % 2) ? 6'h3D : 6'h3E, 8'hFE);
    repeat (3) cyc(6'h3F, 8'hFF);
    chk("sat_err_cnt", 64'(err_cnt), 64'd255);
    chk("sat_err_pulses", 64'(n_err), 64'd300);
    chk("sat_slots", 64'(digit_val), 64'hE88888);

    // Reset in the middle of a run discards it; the next run counts afresh.
    repeat (3) cyc(6'h3F, 8'hFF);
    repeat (2) cyc(6'h3E, 8'hC0);
    sys_rst = 1'b1;
    cyc(6'h3E, 8'hC0);
    sys_rst = 1'b0;
    chk("midrst_val", 64'(digit_val), 64'h0);
    chk("midrst_flags", {56'h0, digit_valid, digit_dp, upd_pulse, err_pulse, err_cnt}, 64'h0);
    n_upd = 0;
    repeat (SC + LAT) cyc(6'h3E, 8'hC0);
    chk("midrst_no_early", 64'(n_upd), 64'd0);
    cyc(6'h3E, 8'hC0);
    chk("midrst_commit", 64'({n_upd[7:0], digit_valid}), 64'({8'd1, 6'h01}));

    for (int c = 0; c < 150; c++) begin
      k = $urandom_range(0, 3);
      one = 6'b1 << $urandom_range(0, 5);
      if (k == 0) rsel = 6'h00;
      else if (k == 3) rsel = 6'($urandom);
      else rsel = ~one;
      k = $urandom_range(0, 19);
      if (k < 16) rled[6:0] = HEX_TAB[k];
      else if (k < 18) rled[6:0] = 7'h7F;
      else rled[6:0] = 7'($urandom);
      rled[7] = 1'($urandom_range(0, 1));
      hold = $urandom_range(1, 7);
      repeat (hold) cyc(rsel, rled);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
